mul_div_unit: RTL

Iterative signed 32x32 multiply and divide datapath unit for the bus-based CPU.
- Consumes the control unit's MUL/DIV strobes, with operand A from the Y register and operand B from the bus.
- Produces the 64-bit Z register contents: HI/LO halves.
- The control unit holds in its mul/div execute state until Done, then moves ZHigh/ZLow to HI/LO.

---
 rtl/mul_div_unit_pkg.sv | 21 ++
 rtl/mul_div_unit_if.sv | 33 +++
 rtl/mul_div_unit_abs_neg.sv | 20 ++
 rtl/mul_div_unit.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/mul_div_unit_pkg.sv
// ---------------------------------------------------------------------------
// mul_div_unit_pkg
// Shared definitions for the iterative multiply/divide unit: operation codes,
// the sequencer state encoding and the native word width of the CPU.
// ---------------------------------------------------------------------------
package mul_div_unit_pkg;

    localparam int WORD_W = 32;

    localparam logic MD_OP_MUL = 1'b0;
    localparam logic MD_OP_DIV = 1'b1;

    typedef enum logic [2:0] {
        MD_IDLE,
        MD_PREP,
        MD_RUN,
        MD_FIX,
        MD_DONE
    } md_state_e;

endpackage

// File: rtl/mul_div_unit_if.sv
// ---------------------------------------------------------------------------
// mul_div_unit_if
// Connection between the control unit (master) and the multiply/divide unit
// (slave).
//   Start, Op      : request strobe and operation select (0 mul, 1 div)
//   A, B           : operand A (Y register), operand B (bus)
//   Busy, Done     : operation in progress / one-cycle completion pulse
//   ZHigh, ZLow    : 64-bit result halves (HI/LO)
//   DivByZero      : flags a divide with a zero divisor
// ---------------------------------------------------------------------------
interface mul_div_unit_if #(
    parameter int WIDTH = mul_div_unit_pkg::WORD_W
);
    logic             Start;
    logic             Op;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Busy;
    logic             Done;
    logic [WIDTH-1:0] ZHigh;
    logic [WIDTH-1:0] ZLow;
    logic             DivByZero;

    modport master (
        output Start, Op, A, B,
        input  Busy, Done, ZHigh, ZLow, DivByZero
    );

    modport slave (
        input  Start, Op, A, B,
        output Busy, Done, ZHigh, ZLow, DivByZero
    );
endinterface

// File: rtl/mul_div_unit_abs_neg.sv
// ---------------------------------------------------------------------------
// md_abs_neg
// Combinational conditional two's-complement negate.
//   val_i : input word
//   neg_i : 1 -> output is -val_i (mod 2^WIDTH), 0 -> output is val_i
//   res_o : result
// Used both to take magnitudes (neg_i = sign bit) and to restore signs.
// Negating zero yields zero, so a zero result never picks up a sign.
// ---------------------------------------------------------------------------
module md_abs_neg #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] val_i,
    input  logic             neg_i,
    output logic [WIDTH-1:0] res_o
);

    assign res_o = neg_i ? (~val_i + WIDTH'(1)) : val_i;

endmodule

// File: rtl/mul_div_unit.sv
// ---------------------------------------------------------------------------
// mul_div_unit
// Iterative signed WIDTH x WIDTH multiply (shift-add) and divide (restoring)
// unit. Works on magnitudes for WIDTH iterations, then applies signs.
//   Clock  : rising-edge clock
//   Reset  : asynchronous, active-high reset
//   bus    : slave side of mul_div_unit_if (Start/Op/A/B in,
//            Busy/Done/ZHigh/ZLow/DivByZero out)
// Results: multiply -> {ZHigh,ZLow} = product; divide -> ZLow = quotient,
// ZHigh = remainder (sign follows the dividend).
// ---------------------------------------------------------------------------
module mul_div_unit
    import mul_div_unit_pkg::*;
#(
    parameter int WIDTH = WORD_W,
    parameter int CNT_W = 6
) (
    input  logic          Clock,
    input  logic          Reset,
    mul_div_unit_if.slave bus
);

    md_state_e              state_q, state_d;
    logic                   op_q, op_d;
    logic [WIDTH-1:0]       a_q, a_d;
    logic [WIDTH-1:0]       b_q, b_d;
    logic                   qsign_q, qsign_d;
    logic                   rsign_q, rsign_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [2*WIDTH-1:0]     work_q, work_d;
    logic [WIDTH-1:0]       opnd_q, opnd_d;
    logic [WIDTH-1:0]       zhi_q, zhi_d;
    logic [WIDTH-1:0]       zlo_q, zlo_d;
    logic                   dz_q, dz_d;

    logic [WIDTH-1:0]       mag_a, mag_b;
    logic [2*WIDTH-1:0]     prod_fix;
    logic [WIDTH-1:0]       quo_fix, rem_fix;

    logic [WIDTH:0]         mul_sum;
    logic [2*WIDTH-1:0]     mul_next;
    logic [2*WIDTH-1:0]     div_shift;
    logic [WIDTH:0]         div_trial;
    logic [2*WIDTH-1:0]     div_next;
    logic                   div_zero;

    // Magnitudes of the latched operands (|most-negative| stays representable
    // as an unsigned WIDTH-bit value).
    md_abs_neg #(.WIDTH(WIDTH)) u_abs_a (
        .val_i (a_q),
        .neg_i (a_q[WIDTH-1]),
        .res_o (mag_a)
    );

    md_abs_neg #(.WIDTH(WIDTH)) u_abs_b (
        .val_i (b_q),
        .neg_i (b_q[WIDTH-1]),
        .res_o (mag_b)
    );

    // Sign correction of the finished magnitude results.
    md_abs_neg #(.WIDTH(2*WIDTH)) u_fix_prod (
        .val_i (work_q),
        .neg_i (qsign_q),
        .res_o (prod_fix)
    );

    md_abs_neg #(.WIDTH(WIDTH)) u_fix_quo (
        .val_i (work_q[WIDTH-1:0]),
        .neg_i (qsign_q),
        .res_o (quo_fix)
    );

    md_abs_neg #(.WIDTH(WIDTH)) u_fix_rem (
        .val_i (work_q[2*WIDTH-1:WIDTH]),
        .neg_i (rsign_q),
        .res_o (rem_fix)
    );

    assign div_zero = (op_q == MD_OP_DIV) && (b_q == '0);

    // Shift-add step on {acc, multiplier}: the 33-bit sum keeps the carry,
    // which becomes the new acc MSB after the right shift.
    assign mul_sum  = {1'b0, work_q[2*WIDTH-1:WIDTH]}
                    + {1'b0, (work_q[0] ? opnd_q : {WIDTH{1'b0}})};
    assign mul_next = {mul_sum, work_q[WIDTH-1:1]};

    // Restoring step on {rem, quo}: rem < divisor always holds, so the
    // shifted remainder fits in WIDTH bits; bit WIDTH of the trial is the
    // borrow.
    assign div_shift = work_q << 1;
    assign div_trial = {1'b0, div_shift[2*WIDTH-1:WIDTH]} - {1'b0, opnd_q};
    assign div_next  = div_trial[WIDTH]
                     ? div_shift
                     : {div_trial[WIDTH-1:0], div_shift[WIDTH-1:1], 1'b1};

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q <= MD_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            op_q    <= MD_OP_MUL;
            a_q     <= '0;
            b_q     <= '0;
            qsign_q <= 1'b0;
            rsign_q <= 1'b0;
            cnt_q   <= '0;
            work_q  <= '0;
            opnd_q  <= '0;
            zhi_q   <= '0;
            zlo_q   <= '0;
            dz_q    <= 1'b0;
        end else begin
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            qsign_q <= qsign_d;
            rsign_q <= rsign_d;
            cnt_q   <= cnt_d;
            work_q  <= work_d;
            opnd_q  <= opnd_d;
            zhi_q   <= zhi_d;
            zlo_q   <= zlo_d;
            dz_q    <= dz_d;
        end
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        qsign_d = qsign_q;
        rsign_d = rsign_q;
        cnt_d   = cnt_q;
        work_d  = work_q;
        opnd_d  = opnd_q;
        zhi_d   = zhi_q;
        zlo_d   = zlo_q;
        dz_d    = dz_q;

        unique case (state_q)
            MD_IDLE: begin
                if (bus.Start) begin
                    op_d    = bus.Op;
                    a_d     = bus.A;
                    b_d     = bus.B;
                    dz_d    = 1'b0;
                    state_d = MD_PREP;
                end
            end

            MD_PREP: begin
                qsign_d = a_q[WIDTH-1] ^ b_q[WIDTH-1];
                rsign_d = a_q[WIDTH-1];
                cnt_d   = '0;
                if (div_zero) begin
                    // No iterations; FIX writes the fixed divide-by-zero
                    // pattern so the flag appears together with Done.
                    state_d = MD_FIX;
                end else begin
                    if (op_q == MD_OP_DIV) begin
                        work_d = {{WIDTH{1'b0}}, mag_a};
                        opnd_d = mag_b;
                    end else begin
                        work_d = {{WIDTH{1'b0}}, mag_b};
                        opnd_d = mag_a;
                    end
                    state_d = MD_RUN;
                end
            end

            MD_RUN: begin
                work_d = (op_q == MD_OP_DIV) ? div_next : mul_next;
                cnt_d  = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d = MD_FIX;
                end
            end

            MD_FIX: begin
                if (div_zero) begin
                    zlo_d = '1;
                    zhi_d = a_q;
                    dz_d  = 1'b1;
                end else if (op_q == MD_OP_DIV) begin
                    zlo_d = quo_fix;
                    zhi_d = rem_fix;
                end else begin
                    zlo_d = prod_fix[WIDTH-1:0];
                    zhi_d = prod_fix[2*WIDTH-1:WIDTH];
                end
                state_d = MD_DONE;
            end

            MD_DONE: begin
                state_d = MD_IDLE;
            end

            default: begin
                state_d = MD_IDLE;
            end
        endcase
    end

    assign bus.Busy      = (state_q == MD_PREP) || (state_q == MD_RUN)
                        || (state_q == MD_FIX);
    assign bus.Done      = (state_q == MD_DONE);
    assign bus.ZHigh     = zhi_q;
    assign bus.ZLow      = zlo_q;
    assign bus.DivByZero = dz_q;

endmodule
